// File: rtl/lut_mux_pkg.sv
// ---------------------------------------------------------------------------
// lut_mux_pkg
// Shared constants and types for the programmable key/value lookup mux.
//   LUT_MUX_NR_KEY   : default number of table entries
//   LUT_MUX_KEY_LEN  : default key width
//   LUT_MUX_DATA_LEN : default data width
//   lut_entry_t      : one table entry {vld, key, data} at the default widths
// Optional feature macro used by the design: LUT_MUX_PIPE_PRIORITY_EN
// ---------------------------------------------------------------------------
package lut_mux_pkg;

  localparam int LUT_MUX_NR_KEY   = 4;
  localparam int LUT_MUX_KEY_LEN  = 2;
  localparam int LUT_MUX_DATA_LEN = 2;

  typedef struct packed {
    logic                        vld;
    logic [LUT_MUX_KEY_LEN-1:0]  key;
    logic [LUT_MUX_DATA_LEN-1:0] data;
  } lut_entry_t;

endpackage

// File: rtl/lut_mux_match.sv
// ---------------------------------------------------------------------------
// lut_mux_match
// Purely combinational key match and data selection over the lookup table.
// Ports:
//   vld_i        : per-entry valid bits
//   key_i        : per-entry keys (packed, entry i at [i])
//   data_i       : per-entry data (packed, entry i at [i])
//   lookup_key_i : key being looked up
//   hit_o        : at least one valid entry matched
//   data_o       : selected data, or DEFAULT_OUT when nothing matched
// Macro LUT_MUX_PIPE_PRIORITY_EN: when defined, the lowest-index match wins;
// when undefined, the data of every matching entry is ORed together.
// ---------------------------------------------------------------------------
module lut_mux_match
  import lut_mux_pkg::*;
#(
  parameter int                  NR_KEY      = LUT_MUX_NR_KEY,
  parameter int                  KEY_LEN     = LUT_MUX_KEY_LEN,
  parameter int                  DATA_LEN    = LUT_MUX_DATA_LEN,
  parameter logic [DATA_LEN-1:0] DEFAULT_OUT = '0
) (
  input  logic [NR_KEY-1:0]               vld_i,
  input  logic [NR_KEY-1:0][KEY_LEN-1:0]  key_i,
  input  logic [NR_KEY-1:0][DATA_LEN-1:0] data_i,
  input  logic [KEY_LEN-1:0]              lookup_key_i,
  output logic                            hit_o,
  output logic [DATA_LEN-1:0]             data_o
);

  logic [NR_KEY-1:0]   match;
  logic [DATA_LEN-1:0] sel;

  always_comb begin
    match = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      match[i] = vld_i[i] && (key_i[i] == lookup_key_i);
    end
  end

`ifdef LUT_MUX_PIPE_PRIORITY_EN
  // Walk from the highest index down so the lowest matching index is the
  // last one written and therefore wins.
  always_comb begin
    sel = '0;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (match[i]) begin
        sel = data_i[i];
      end
    end
  end
`else
  always_comb begin
    sel = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      if (match[i]) begin
        sel = sel | data_i[i];
      end
    end
  end
`endif

  assign hit_o  = |match;
  assign data_o = hit_o ? sel : DEFAULT_OUT;

endmodule

// File: rtl/lut_mux_pipe.sv
// ---------------------------------------------------------------------------
// lut_mux_pipe
// Runtime-programmable key/value lookup table with a registered valid/ready
// output stage and a saturating miss counter.
// Ports:
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   cfg_we, cfg_idx   : table write strobe and entry index (out of range = ignored)
//   cfg_key/data/vld  : contents written into the addressed entry
//   in_valid/in_ready : lookup request handshake, in_key is the lookup key
//   out_valid/ready   : result handshake toward the consumer
//   out_data, out_hit : registered lookup result (DEFAULT_OUT on miss)
//   miss_cnt          : saturating count of accepted lookups that missed
// Macro LUT_MUX_PIPE_PRIORITY_EN selects lowest-index-wins on multi-match
// (see lut_mux_match); by default multiple matches are ORed.
// ---------------------------------------------------------------------------
module lut_mux_pipe
  import lut_mux_pkg::*;
#(
  parameter int                  NR_KEY      = LUT_MUX_NR_KEY,
  parameter int                  KEY_LEN     = LUT_MUX_KEY_LEN,
  parameter int                  DATA_LEN    = LUT_MUX_DATA_LEN,
  parameter logic [DATA_LEN-1:0] DEFAULT_OUT = '0,
  parameter int                  CNT_LEN     = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_we,
  input  logic [$clog2(NR_KEY)-1:0] cfg_idx,
  input  logic [KEY_LEN-1:0]        cfg_key,
  input  logic [DATA_LEN-1:0]       cfg_data,
  input  logic                      cfg_vld,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [KEY_LEN-1:0]        in_key,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_LEN-1:0]       out_data,
  output logic                      out_hit,
  output logic [CNT_LEN-1:0]        miss_cnt
);

  localparam int                 IDX_W   = $clog2(NR_KEY);
  localparam logic [CNT_LEN-1:0] CNT_MAX = '1;

  logic [NR_KEY-1:0]               vld_q;
  logic [NR_KEY-1:0][KEY_LEN-1:0]  key_q;
  logic [NR_KEY-1:0][DATA_LEN-1:0] data_q;

  logic                out_valid_q, out_valid_d;
  logic [DATA_LEN-1:0] out_data_q, out_data_d;
  logic                out_hit_q, out_hit_d;
  logic [CNT_LEN-1:0]  miss_cnt_q, miss_cnt_d;

  logic                match_hit;
  logic [DATA_LEN-1:0] match_data;
  logic                accept;

  // Only indices that name a real entry can match below, so writes to an
  // index at or beyond NR_KEY fall through without touching the table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      key_q  <= '0;
      data_q <= '0;
    end else if (cfg_we) begin
      for (int i = 0; i < NR_KEY; i++) begin
        if (cfg_idx == IDX_W'(i)) begin
          vld_q[i]  <= cfg_vld;
          key_q[i]  <= cfg_key;
          data_q[i] <= cfg_data;
        end
      end
    end
  end

  // The matcher reads the registered table, so a lookup in the same cycle
  // as a write still sees the old contents.
  lut_mux_match #(
    .NR_KEY      (NR_KEY),
    .KEY_LEN     (KEY_LEN),
    .DATA_LEN    (DATA_LEN),
    .DEFAULT_OUT (DEFAULT_OUT)
  ) u_match (
    .vld_i        (vld_q),
    .key_i        (key_q),
    .data_i       (data_q),
    .lookup_key_i (in_key),
    .hit_o        (match_hit),
    .data_o       (match_data)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // A new result overwrites the slot; otherwise a consumed result empties
  // it while data/hit simply hold their last values.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_hit_d   = out_hit_q;
    miss_cnt_d  = miss_cnt_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = match_data;
      out_hit_d   = match_hit;
      if (!match_hit && (miss_cnt_q != CNT_MAX)) begin
        miss_cnt_d = miss_cnt_q + CNT_LEN'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_hit_q   <= 1'b0;
      miss_cnt_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_hit_q   <= out_hit_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_hit   = out_hit_q;
  assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_lut_mux_pipe.sv
// ---------------------------------------------------------------------------
// tb_lut_mux_pipe
// Directed-vector bench for lut_mux_pipe with a table-level reference model.
// The DUT runs with a 2-bit miss counter so saturation is reached quickly,
// and with a non-zero DEFAULT_OUT so a miss is distinguishable from reset.
// Honours LUT_MUX_PIPE_PRIORITY_EN for the multi-match expectation.
// ---------------------------------------------------------------------------
module tb_lut_mux_pipe;
  import lut_mux_pkg::*;

  localparam int         NR_KEY   = 4;
  localparam int         KEY_LEN  = 2;
  localparam int         DATA_LEN = 2;
  localparam int         CNT_LEN  = 2;
  localparam logic [1:0] DEF      = 2'b10;
  localparam int         CNT_MAX  = (1 << CNT_LEN) - 1;

  logic                clk = 1'b0;
  logic                rstN;
  logic                cfgWe;
  logic [1:0]          cfgIdx;
  logic [KEY_LEN-1:0]  cfgKey;
  logic [DATA_LEN-1:0] cfgData;
  logic                cfgVld;
  logic                inValid;
  logic                inReady;
  logic [KEY_LEN-1:0]  inKey;
  logic                outValid;
  logic                outReady;
  logic [DATA_LEN-1:0] outData;
  logic                outHit;
  logic [CNT_LEN-1:0]  missCnt;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  lut_mux_pipe #(
    .NR_KEY      (NR_KEY),
    .KEY_LEN     (KEY_LEN),
    .DATA_LEN    (DATA_LEN),
    .DEFAULT_OUT (DEF),
    .CNT_LEN     (CNT_LEN)
  ) dut (
    .clk       (clk),
    .rst_n     (rstN),
    .cfg_we    (cfgWe),
    .cfg_idx   (cfgIdx),
    .cfg_key   (cfgKey),
    .cfg_data  (cfgData),
    .cfg_vld   (cfgVld),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .in_key    (inKey),
    .out_valid (outValid),
    .out_ready (outReady),
    .out_data  (outData),
    .out_hit   (outHit),
    .miss_cnt  (missCnt)
  );

  // Reference model: the table as an array of entries plus the single
  // output slot and the miss tally, updated once per clock.
  lut_entry_t mTable [NR_KEY] = '{default: '0};
  logic       mValid = 1'b0;
  logic [1:0] mData  = 2'b00;
  logic       mHit   = 1'b0;
  int         mCnt   = 0;

  function automatic logic modelHit(input logic [1:0] k);
    logic any = 1'b0;
    for (int i = 0; i < NR_KEY; i++)
      if (mTable[i].vld && mTable[i].key == k) any = 1'b1;
    return any;
  endfunction

  function automatic logic [1:0] modelData(input logic [1:0] k);
    logic [1:0] acc = 2'b00;
    logic       any = 1'b0;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (mTable[i].vld && mTable[i].key == k) begin
`ifdef LUT_MUX_PIPE_PRIORITY_EN
        acc = mTable[i].data;
`else
        acc = acc | mTable[i].data;
`endif
        any = 1'b1;
      end
    end
    return any ? acc : DEF;
  endfunction

  // Model update; the table write lands after the lookup has used the old
  // contents because both are non-blocking.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < NR_KEY; i++) mTable[i] <= '0;
      mValid <= 1'b0;
      mData  <= 2'b00;
      mHit   <= 1'b0;
      mCnt   <= 0;
    end else begin
      if (inValid && (!mValid || outReady)) begin
        mValid <= 1'b1;
        mHit   <= modelHit(inKey);
        mData  <= modelData(inKey);
        if (!modelHit(inKey) && mCnt < CNT_MAX) mCnt <= mCnt + 1;
      end else if (outReady) begin
        mValid <= 1'b0;
      end
      if (cfgWe) mTable[cfgIdx] <= '{vld: cfgVld, key: cfgKey, data: cfgData};
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Continuous comparison against the model on the falling edge.
  always @(negedge clk) begin
    checkOutput("model in_ready", int'(inReady), int'(!mValid || outReady));
    checkOutput("model out_valid", int'(outValid), int'(mValid));
    checkOutput("model miss_cnt", int'(missCnt), mCnt);
    if (mValid || !rstN) begin
      checkOutput("model out_data", int'(outData), int'(mData));
      checkOutput("model out_hit", int'(outHit), int'(mHit));
    end
  end

  task automatic applyStimulus(input logic we, input logic [1:0] idx, input logic [1:0] key,
                               input logic [1:0] data, input logic vld, input logic iv,
                               input logic [1:0] ik, input logic ordy);
    cfgWe    = we;
    cfgIdx   = idx;
    cfgKey   = key;
    cfgData  = data;
    cfgVld   = vld;
    inValid  = iv;
    inKey    = ik;
    outReady = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    rstN = 1'b0;
    tick();
    tick();
    rstN = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int expCnt [5] = '{1, 2, 3, 3, 3};
    $display("[TB] starting lut_mux_pipe bench");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    rstN = 1'b0;
    tick();
    tick();
    checkOutput("reset in_ready", int'(inReady), 1);
    checkOutput("reset out_valid", int'(outValid), 0);
    checkOutput("reset out_data", int'(outData), 0);
    checkOutput("reset out_hit", int'(outHit), 0);
    checkOutput("reset miss_cnt", int'(missCnt), 0);
    rstN = 1'b1;

    // Lookup on an empty table misses with the default value.
    applyStimulus(0, 0, 0, 0, 0, 1, 2'd1, 1);
    tick();
    checkOutput("empty out_valid", int'(outValid), 1);
    checkOutput("empty out_hit", int'(outHit), 0);
    checkOutput("empty out_data", int'(outData), int'(DEF));
    checkOutput("empty miss_cnt", int'(missCnt), 1);

    // Fill the table key i -> 3-i, then look up all keys back-to-back.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 2'(i), 2'(i), 2'(3 - i), 1, 0, 0, 1);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 1, 2'(i), 1);
      tick();
      checkOutput("b2b out_valid", int'(outValid), 1);
      checkOutput("b2b out_hit", int'(outHit), 1);
      checkOutput("b2b out_data", int'(outData), 3 - i);
      checkOutput("b2b miss_cnt", int'(missCnt), 1);
    end

    // Two entries share key 1.
    applyStimulus(1, 2'd0, 2'd1, 2'b01, 1, 0, 0, 1);
    tick();
    applyStimulus(1, 2'd1, 2'd1, 2'b10, 1, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 2'd1, 1);
    tick();
    checkOutput("multi out_hit", int'(outHit), 1);
`ifdef LUT_MUX_PIPE_PRIORITY_EN
    checkOutput("multi out_data", int'(outData), 1);
`else
    checkOutput("multi out_data", int'(outData), 3);
`endif

    // Stall: result held for 3 cycles while a second request waits.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 2'd2, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 2'd3, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("stall in_ready", int'(inReady), 0);
      checkOutput("stall out_valid", int'(outValid), 1);
      checkOutput("stall out_data", int'(outData), 1);
      checkOutput("stall out_hit", int'(outHit), 1);
    end
    applyStimulus(0, 0, 0, 0, 0, 1, 2'd3, 1);
    #1;
    checkOutput("release in_ready", int'(inReady), 1);
    tick();
    checkOutput("release out_data", int'(outData), 0);
    checkOutput("release out_hit", int'(outHit), 1);
    checkOutput("release miss_cnt", int'(missCnt), 1);

    // Write and lookup in the same cycle on an empty table.
    doReset();
    applyStimulus(1, 2'd0, 2'd0, 2'd3, 1, 1, 2'd0, 1);
    tick();
    checkOutput("wr-rd same out_hit", int'(outHit), 0);
    checkOutput("wr-rd same out_data", int'(outData), int'(DEF));
    checkOutput("wr-rd same miss_cnt", int'(missCnt), 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 2'd0, 1);
    tick();
    checkOutput("wr-rd next out_hit", int'(outHit), 1);
    checkOutput("wr-rd next out_data", int'(outData), 3);
    // Clearing the valid bit removes the entry.
    applyStimulus(1, 2'd0, 2'd0, 2'd3, 0, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 2'd0, 1);
    tick();
    checkOutput("removed out_hit", int'(outHit), 0);
    checkOutput("removed miss_cnt", int'(missCnt), 2);

    // Miss counter saturation.
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 1, 2'd1, 1);
      tick();
      checkOutput("sat miss_cnt", int'(missCnt), expCnt[i]);
    end

    // Reset while a result is pending.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("pending out_valid", int'(outValid), 1);
    rstN = 1'b0;
    #1;
    checkOutput("midreset out_valid", int'(outValid), 0);
    checkOutput("midreset miss_cnt", int'(missCnt), 0);
    checkOutput("midreset in_ready", int'(inReady), 1);
    checkOutput("midreset out_data", int'(outData), 0);
    tick();
    rstN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 1, 2'(i), 1);
      tick();
      checkOutput("post-reset out_hit", int'(outHit), 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
